// File: rtl/alu_flag_pipe_if.sv
// alu_flag_pipe_if: instruction/result bundle between the operand stage and the flag ALU
interface alu_flag_pipe_if #(parameter int WIDTH = 16);
   logic             In_valid;
   logic [2:0]       In_op;
   logic [1:0]       In_cond;
   logic [1:0]       In_flag_we;
   logic [WIDTH-1:0] In_A;
   logic [WIDTH-1:0] In_B;
   logic             In_stall;
   logic             In_flush;
   logic             Out_valid;
   logic             Out_wr_en;
   logic [WIDTH-1:0] Out_result;
   logic             Out_CFlag;
   logic             Out_ZFlag;
   modport master (
      output In_valid, In_op, In_cond, In_flag_we, In_A, In_B, In_stall, In_flush,
      input  Out_valid, Out_wr_en, Out_result, Out_CFlag, Out_ZFlag
   );
   modport slave (
      input  In_valid, In_op, In_cond, In_flag_we, In_A, In_B, In_stall, In_flush,
      output Out_valid, Out_wr_en, Out_result, Out_CFlag, Out_ZFlag
   );
endinterface

// File: rtl/alu_flag_pipe.sv
// alu_flag_pipe: registered ADD/SUB/NAND/CMP stage owning the carry and zero flags
module alu_flag_pipe #(parameter int WIDTH = 16) (
   input logic             In_clk,
   input logic             In_reset_n,
   alu_flag_pipe_if.slave  bus
);
   logic             r_valid, r_wr_en, r_c, r_z;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH:0]   w_sum, w_diff;
   logic [WIDTH-1:0] w_res;
   logic             w_add, w_nand, w_cmp, w_sub;
   logic             w_cap, w_cond_ok, w_exec, w_wr, w_c, w_z;
   assign w_add  = bus.In_op == 3'b001;
   assign w_nand = bus.In_op == 3'b010;
   assign w_cmp  = bus.In_op == 3'b011;
   assign w_sub  = bus.In_op == 3'b100;
   assign w_sum  = {1'b0, bus.In_A} + {1'b0, bus.In_B};
   assign w_diff = {1'b0, bus.In_A} - {1'b0, bus.In_B};
   assign w_cap     = bus.In_valid & ~bus.In_stall & ~bus.In_flush;
   // Condition is judged against the flags as they stand before this edge
   assign w_cond_ok = (bus.In_cond == 2'b01) ? r_z : (bus.In_cond == 2'b10) ? r_c : 1'b1;
   assign w_exec    = w_cap & w_cond_ok & (w_add | w_nand | w_cmp | w_sub);
   assign w_wr      = w_exec & ~w_cmp;
   assign w_res = w_add ? w_sum[WIDTH-1:0] : w_sub ? w_diff[WIDTH-1:0] : ~(bus.In_A & bus.In_B);
   // Borrow out of the widened subtract is the inverse of carry
   assign w_c   = w_add ? w_sum[WIDTH] : ~w_diff[WIDTH];
   assign w_z   = w_cmp ? (bus.In_A == bus.In_B) : (w_res == '0);
   always_ff @(posedge In_clk) begin
      if (!In_reset_n) begin
         r_valid  <= 1'b0;
         r_wr_en  <= 1'b0;
         r_result <= '0;
         r_c      <= 1'b0;
         r_z      <= 1'b0;
      end else if (bus.In_flush || !bus.In_stall) begin
         r_valid <= w_cap;
         r_wr_en <= w_wr;
         if (w_wr) r_result <= w_res;
         if (w_exec && (w_add || w_sub) && bus.In_flag_we[1]) r_c <= w_c;
         if (w_exec && bus.In_flag_we[0]) r_z <= w_z;
      end
   end
   assign bus.Out_valid  = r_valid;
   assign bus.Out_wr_en  = r_wr_en;
   assign bus.Out_result = r_result;
   assign bus.Out_CFlag  = r_c;
   assign bus.Out_ZFlag  = r_z;
endmodule

// File: tb/tb_alu_flag_pipe.sv
// tb_alu_flag_pipe: scoreboard bench for alu_flag_pipe with directed and random stimulus
module tb_alu_flag_pipe;
   localparam int W = 16;
   typedef struct {
      logic         v, wr, c, z;
      logic [W-1:0] r;
      int           id;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   alu_flag_pipe_if #(.WIDTH(W)) bus ();
   alu_flag_pipe_if #(.WIDTH(8)) bus8 ();
   alu_flag_pipe #(.WIDTH(W)) u_dut (.In_clk(clk), .In_reset_n(rst_n), .bus(bus));
   alu_flag_pipe #(.WIDTH(8)) u_dut8 (.In_clk(clk), .In_reset_n(rst_n), .bus(bus8));
   exp_t q[$];
   int n_chk = 0;
   int n_fail = 0;
   int n_id = 0;
   logic         m_v = 0, m_wr = 0, m_c = 0, m_z = 0;
   logic [W-1:0] m_r = '0;
   task automatic drive(input logic rn, input logic v, input logic [2:0] op, input logic [1:0] cond,
                        input logic [1:0] fwe, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic st, input logic fl);
      int s;
      logic ok, cf;
      logic [W-1:0] res;
      exp_t e;
      @(negedge clk);
      rst_n = rn;
      bus.In_valid = v; bus.In_op = op; bus.In_cond = cond; bus.In_flag_we = fwe;
      bus.In_A = a; bus.In_B = b; bus.In_stall = st; bus.In_flush = fl;
      if (!rn) begin
         m_v = 0; m_wr = 0; m_r = '0; m_c = 0; m_z = 0;
      end else if (fl) begin
         m_v = 0; m_wr = 0;
      end else if (!st) begin
         m_v = v;
         m_wr = 0;
         ok = (cond == 2'd1) ? m_z : (cond == 2'd2) ? m_c : 1'b1;
         if (v && ok) begin
            res = '0;
            cf = 0;
            if (op == 3'd1) begin
               s = int'(a) + int'(b);
               res = W'(s % (1 << W));
               cf = s >= (1 << W);
            end else if (op == 3'd4) begin
               s = int'(a) - int'(b) + (1 << W);
               res = W'(s % (1 << W));
               cf = a >= b;
            end else if (op == 3'd2) begin
               res = ~(a & b);
            end
            if (op == 3'd1 || op == 3'd2 || op == 3'd4) begin
               m_r = res;
               m_wr = 1;
               if (fwe[0]) m_z = (res == 0);
               if (fwe[1] && op != 3'd2) m_c = cf;
            end else if (op == 3'd3 && fwe[0]) begin
               m_z = (a == b);
            end
         end
      end
      e.v = m_v; e.wr = m_wr; e.c = m_c; e.z = m_z; e.r = m_r; e.id = n_id;
      n_id++;
      q.push_back(e);
   endtask
   task automatic op1(input logic [2:0] op, input logic [1:0] cond, input logic [1:0] fwe,
                      input logic [W-1:0] a, input logic [W-1:0] b);
      drive(1, 1, op, cond, fwe, a, b, 0, 0);
   endtask
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            n_chk++;
            if (bus.Out_valid !== e.v || bus.Out_wr_en !== e.wr || bus.Out_result !== e.r ||
                bus.Out_CFlag !== e.c || bus.Out_ZFlag !== e.z) begin
               n_fail++;
               $display("FAIL cycle%0d: got v=%b wr=%b r=%h c=%b z=%b, expected v=%b wr=%b r=%h c=%b z=%b",
                        e.id, bus.Out_valid, bus.Out_wr_en, bus.Out_result, bus.Out_CFlag, bus.Out_ZFlag,
                        e.v, e.wr, e.r, e.c, e.z);
            end
         end
      end
   end
   initial begin : stim
      bus8.In_valid = 0; bus8.In_op = 0; bus8.In_cond = 0; bus8.In_flag_we = 0;
      bus8.In_A = 0; bus8.In_B = 0; bus8.In_stall = 0; bus8.In_flush = 0;
      drive(0, 1, 3'd1, 0, 2'b11, 16'h1234, 16'h4321, 0, 0);
      drive(0, 0, 3'd0, 0, 2'b00, 16'h0, 16'h0, 0, 0);
      op1(3'd1, 0, 2'b11, 16'hFFFF, 16'h0001);
      op1(3'd1, 0, 2'b11, 16'h0001, 16'h0001);
      op1(3'd1, 2'b10, 2'b11, 16'h0005, 16'h0005);
      op1(3'd1, 0, 2'b11, 16'hFFFF, 16'h0002);
      op1(3'd1, 2'b10, 2'b11, 16'h0003, 16'h0004);
      op1(3'd4, 0, 2'b11, 16'h0005, 16'h0007);
      op1(3'd3, 0, 2'b11, 16'h1234, 16'h1234);
      op1(3'd4, 0, 2'b11, 16'h0005, 16'h0003);
      op1(3'd2, 0, 2'b11, 16'hFFFF, 16'hFFFF);
      op1(3'd2, 0, 2'b00, 16'h0000, 16'h0000);
      op1(3'd1, 2'b01, 2'b11, 16'h0010, 16'h0020);
      op1(3'd7, 0, 2'b11, 16'h0001, 16'h0001);
      drive(1, 0, 3'd1, 0, 2'b11, 16'h1, 16'h1, 0, 0);
      op1(3'd1, 0, 2'b11, 16'h00F0, 16'h000F);
      repeat (3) drive(1, 1, 3'd1, 0, 2'b11, 16'hFFFF, 16'h0001, 1, 0);
      drive(1, 1, 3'd1, 0, 2'b11, 16'hFFFF, 16'h0001, 1, 1);
      drive(1, 1, 3'd1, 0, 2'b11, 16'hFFFF, 16'h0001, 0, 1);
      op1(3'd1, 0, 2'b11, 16'hFFFF, 16'h0001);
      drive(1, 1, 3'd1, 0, 2'b11, 16'h0001, 16'h0001, 1, 0);
      drive(0, 1, 3'd1, 0, 2'b11, 16'h0001, 16'h0001, 1, 0);
      op1(3'd4, 0, 2'b11, 16'h0000, 16'h0000);
      for (int i = 0; i < 400; i++) begin
         logic [W-1:0] a, b;
         a = ($urandom_range(0, 5) == 0) ? W'(16'hFFFF) : W'($urandom);
         b = ($urandom_range(0, 5) == 0) ? a : W'($urandom);
         drive($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
               2'($urandom), 2'($urandom), a, b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      end
      drive(1, 0, 3'd0, 0, 2'b00, 16'h0, 16'h0, 0, 0);
      repeat (4) @(posedge clk);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      @(negedge clk);
      rst_n = 1;
      bus8.In_valid = 1; bus8.In_op = 3'd1; bus8.In_flag_we = 2'b11; bus8.In_A = 8'hFF; bus8.In_B = 8'h01;
      @(negedge clk);
      bus8.In_valid = 0;
      n_chk++;
      if (bus8.Out_result !== 8'h00 || bus8.Out_CFlag !== 1'b1 || bus8.Out_ZFlag !== 1'b1 ||
          bus8.Out_wr_en !== 1'b1 || bus8.Out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL width8_add: got r=%h c=%b z=%b wr=%b v=%b, expected r=00 c=1 z=1 wr=1 v=1",
                  bus8.Out_result, bus8.Out_CFlag, bus8.Out_ZFlag, bus8.Out_wr_en, bus8.Out_valid);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
